sipo_frame_deser: RTL and testbench
===================================

Name: sipo_frame_deser

Overview:
- Serial-in/parallel-out deserializer that sits directly upstream of the PIPO register stage.
- Collects WIDTH serial bits per frame, marked by a start strobe, into a parallel word.
- Presents each word on a holding register with a valid/ready handshake, so the downstream PIPO loads one complete word at a time.
- Flags overflow when a word is lost because the consumer stalled.

Parameters:
- WIDTH, 5, data bits per frame and parallel output width; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_vld  input  1  sin is sampled only on edges where sin_vld=1.
- start  input  1  qualifies the sampled bit as the first bit of a frame; ignored when sin_vld=0.
- pout  output  WIDTH  assembled word (holding register).
- pout_vld  output  1  pout holds an unconsumed word.
- pout_rdy  input  1  downstream accepts pout on edges where pout_vld=1 and pout_rdy=1.
- busy  output  1  a frame is in progress (state != IDLE).
- ovf  output  1  sticky overflow flag.
- par_err  output  1  parity error for the word on pout; see Optional Feature.

Behaviour:
- Reset: one clock, synchronous, active-high, on clk with clr=1. Values after reset:
  - pout=0, pout_vld=0, busy=0, ovf=0, par_err=0.
  - Shift register and bit counter = 0; state = IDLE.
  - clr overrides every other input in the same cycle.
  - clr asserted mid-frame discards the partial frame.
  - clr asserted with pout_vld=1 discards the held word.
- Shift order is LSB first: sreg <= {sin, sreg[WIDTH-1:1]}. After WIDTH bits, the first received bit sits at bit 0.
- Bit counter: counts 1..WIDTH, width $clog2(WIDTH+1).
- States:
  - IDLE:
    - sin_vld=1 with start=1: capture the bit, cnt=1, go to SHIFT.
    - sin_vld=1 with start=0: ignored.
  - SHIFT:
    - sin_vld=1 with start=0: capture the bit, cnt++.
    - sin_vld=1 with start=1: restart the frame; the partial frame is dropped silently, the bit becomes bit 1, cnt=1.
    - The edge capturing bit WIDTH completes the frame: state returns to IDLE, or to PAR when PARITY_CHK_EN is defined.
  - sin_vld=0: state and counter hold in every state.
- Completion, when the frame-completing edge is edge N:
  - Assembled word is written to pout.
  - pout_vld=1 is visible immediately after edge N.
  - Latency: zero extra cycles after the last bit.
- Handshake:
  - pout and pout_vld change only on completion or on handshake.
  - pout stays stable while pout_vld=1 and pout_rdy=0.
  - Handshake edge with no completion on the same edge: pout_vld <= 0; pout retains its last value.
- Completion and handshake on the same edge: the new word loads, pout_vld stays 1. No overflow.
- Completion while pout_vld=1 and pout_rdy=0:
  - New word is dropped; held word is preserved.
  - ovf <= 1. ovf is sticky until clr.
- busy=1 in SHIFT and in PAR.

Optional Feature:
- Macro: PARITY_CHK_EN.
- Defined:
  - After bit WIDTH, the FSM enters PAR and the next sin_vld bit is taken as an even-parity bit. start is ignored in PAR.
  - Completion happens on the parity edge, not on bit WIDTH.
  - par_err <= (^data) ^ parity_bit, loaded together with pout.
  - par_err is held and cleared exactly like pout_vld.
- Undefined:
  - No PAR state.
  - par_err is constant 0; the port is still present.

Test Plan:
- Reset: hold clr=1 for 2 cycles with random sin/sin_vld/start toggling -> pout=0, pout_vld=0, busy=0, ovf=0 throughout.
- Basic frame, WIDTH=5, pout_rdy=1:
  - Stimulus: bits 1,0,1,1,0 on consecutive edges, start on the first.
  - Expect pout=5'b01101, pout_vld=1 right after the 5th edge, cleared one edge later; busy high for edges 1..4.
- Gapped input and stall:
  - Stimulus: frame 1,1,1,1,1 with sin_vld low every other cycle; pout_rdy=0.
  - Expect pout=5'b11111, pout_vld held until pout_rdy=1, then cleared on that edge.
- Overflow:
  - Stimulus: with pout_rdy=0, frame 5'b00011, then frame 5'b10100.
  - Expect pout stays 5'b00011 and ovf=1; ovf stays 1 after the handshake until clr.
- Back-to-back frames: second frame completes on the same edge as the handshake of the first -> pout updates to the second word, pout_vld stays 1, ovf=0.
- Mid-frame restart:
  - Stimulus: start, 3 bits, then start with bits 0,0,0,0,1.
  - Expect pout=5'b10000.
  - With PARITY_CHK_EN: parity bit 1 gives par_err=0; parity bit 0 gives par_err=1.

Source files
------------

// File: rtl/sipo_frame_deser.sv
// Serial-in/parallel-out frame deserializer with a valid/ready holding register.
// Define PARITY_CHK_EN to expect a trailing even-parity bit per frame and report par_err.
module sipo_frame_deser #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             start,
  output logic [WIDTH-1:0] pout,
  output logic             pout_vld,
  input  logic             pout_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_CHK_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;

  assign shifted = {sin, sreg[WIDTH-1:1]};
  assign busy    = (state != IDLE);

`ifdef PARITY_CHK_EN
  logic perr;
  // The word is already complete in sreg; the parity edge only delivers the check bit.
  assign done = (state == PAR) && sin_vld;
  assign word = sreg;
  assign perr = (^sreg) ^ sin;
`else
  logic unused_lsb;
  assign done       = (state == SHIFT) && sin_vld && !start && (cnt == LAST);
  assign word       = shifted;
  assign par_err    = 1'b0;
  assign unused_lsb = sreg[0];
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (sin_vld) begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg  <= {sin, {(WIDTH-1){1'b0}}};
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            sreg <= {sin, {(WIDTH-1){1'b0}}};
            cnt  <= CW'(1);
          end else begin
            sreg <= shifted;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
`ifdef PARITY_CHK_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef PARITY_CHK_EN
        PAR: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // A completed word is dropped (and flagged) only if the held word is stalled.
  always_ff @(posedge clk) begin
    if (clr) begin
      pout     <= '0;
      pout_vld <= 1'b0;
      ovf      <= 1'b0;
`ifdef PARITY_CHK_EN
      par_err  <= 1'b0;
`endif
    end else if (done) begin
      if (pout_vld && !pout_rdy) begin
        ovf <= 1'b1;
      end else begin
        pout     <= word;
        pout_vld <= 1'b1;
`ifdef PARITY_CHK_EN
        par_err  <= perr;
`endif
      end
    end else if (pout_vld && pout_rdy) begin
      pout_vld <= 1'b0;
`ifdef PARITY_CHK_EN
      par_err  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sipo_frame_deser.sv
// Bench for sipo_frame_deser: directed scenarios plus random traffic against a
// bit-queue reference model; honours PARITY_CHK_EN when defined.
module tb_sipo_frame_deser;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic         sinVld = 1'b0;
  logic         start = 1'b0;
  logic         poutRdy = 1'b0;
  logic [W-1:0] pout;
  logic         poutVld;
  logic         busy;
  logic         ovf;
  logic         parErr;

  int nChecks = 0;
  int nErr = 0;

  bit           bits[$];
  bit           inFrame = 1'b0;
  logic [W-1:0] expPout = '0;
  logic         expVld = 1'b0;
  logic         expOvf = 1'b0;
  logic         expPerr = 1'b0;

  sipo_frame_deser #(.WIDTH(W)) dut (
    .clk(clk),
    .clr(clr),
    .sin(sin),
    .sin_vld(sinVld),
    .start(start),
    .pout(pout),
    .pout_vld(poutVld),
    .pout_rdy(poutRdy),
    .busy(busy),
    .ovf(ovf),
    .par_err(parErr)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame content is tracked as a plain list of received bits.
  task automatic modelStep();
    logic [W-1:0] w;
    bit           done;
    logic         pe;
    w = '0;
    done = 1'b0;
    pe = 1'b0;
    if (clr) begin
      bits.delete();
      inFrame = 1'b0;
      expPout = '0;
      expVld  = 1'b0;
      expOvf  = 1'b0;
      expPerr = 1'b0;
    end else begin
      if (sinVld) begin
`ifdef PARITY_CHK_EN
        if (inFrame && bits.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = bits[i];
          pe = (^w) ^ sin;
          done = 1'b1;
          inFrame = 1'b0;
          bits.delete();
        end else
`endif
        if (start) begin
          bits.delete();
          bits.push_back(sin);
          inFrame = 1'b1;
        end else if (inFrame) begin
          bits.push_back(sin);
`ifndef PARITY_CHK_EN
          if (bits.size() == W) begin
            for (int i = 0; i < W; i++) w[i] = bits[i];
            done = 1'b1;
            inFrame = 1'b0;
            bits.delete();
          end
`endif
        end
      end
      if (done) begin
        if (expVld && !poutRdy) begin
          expOvf = 1'b1;
        end else begin
          expPout = w;
          expVld  = 1'b1;
          expPerr = pe;
        end
      end else if (expVld && poutRdy) begin
        expVld  = 1'b0;
        expPerr = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("pout", 32'(pout), 32'(expPout));
    checkValue("pout_vld", 32'(poutVld), 32'(expVld));
    checkValue("busy", 32'(busy), 32'(inFrame));
    checkValue("ovf", 32'(ovf), 32'(expOvf));
    checkValue("par_err", 32'(parErr), 32'(expPerr));
  endtask

  task automatic applyStimulus(input logic c, input logic s, input logic v, input logic st, input logic r);
    clr = c;
    sin = s;
    sinVld = v;
    start = st;
    poutRdy = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), r);
  endtask

  // rdyLast applies on the frame-completing edge (the parity edge when enabled).
  task automatic sendFrame(input logic [W-1:0] data, input logic rdyBody, input logic rdyLast, input bit gap);
    for (int i = 0; i < W; i++) begin
      if (gap && i > 0) idleCycle(rdyBody);
`ifdef PARITY_CHK_EN
      applyStimulus(1'b0, data[i], 1'b1, (i == 0), rdyBody);
`else
      applyStimulus(1'b0, data[i], 1'b1, (i == 0), (i == W - 1) ? rdyLast : rdyBody);
`endif
    end
`ifdef PARITY_CHK_EN
    if (gap) idleCycle(rdyBody);
    applyStimulus(1'b0, ^data, 1'b1, 1'b0, rdyLast);
`endif
  endtask

  initial begin
    logic [W-1:0] restartBits;

    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkValue("reset_pout", 32'(pout), 32'd0);

    $display("[TB] basic frame");
    sendFrame(5'b01101, 1'b1, 1'b1, 1'b0);
    checkValue("basic_pout", 32'(pout), 32'h0d);
    checkValue("basic_vld", 32'(poutVld), 32'd1);
    idleCycle(1'b1);
    checkValue("basic_vld_clr", 32'(poutVld), 32'd0);

    $display("[TB] gapped input and stall");
    sendFrame(5'b11111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idleCycle(1'b0);
    checkValue("stall_pout", 32'(pout), 32'h1f);
    idleCycle(1'b1);
    checkValue("stall_release", 32'(poutVld), 32'd0);

    $display("[TB] overflow");
    sendFrame(5'b00011, 1'b0, 1'b0, 1'b0);
    sendFrame(5'b10100, 1'b0, 1'b0, 1'b0);
    checkValue("ovf_pout", 32'(pout), 32'h03);
    checkValue("ovf_flag", 32'(ovf), 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkValue("ovf_sticky", 32'(ovf), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("ovf_cleared", 32'(ovf), 32'd0);

    $display("[TB] back-to-back");
    sendFrame(5'b01010, 1'b0, 1'b0, 1'b0);
    sendFrame(5'b10011, 1'b0, 1'b1, 1'b0);
    checkValue("b2b_pout", 32'(pout), 32'h13);
    checkValue("b2b_vld", 32'(poutVld), 32'd1);
    checkValue("b2b_ovf", 32'(ovf), 32'd0);
    idleCycle(1'b1);

    $display("[TB] mid-frame restart");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    restartBits = 5'b10000;
    for (int i = 0; i < W; i++)
      applyStimulus(1'b0, restartBits[i], 1'b1, (i == 0), 1'b0);
`ifdef PARITY_CHK_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkValue("restart_perr_ok", 32'(parErr), 32'd0);
    idleCycle(1'b1);
    for (int i = 0; i < W; i++)
      applyStimulus(1'b0, restartBits[i], 1'b1, (i == 0), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("restart_perr_bad", 32'(parErr), 32'd1);
`endif
    checkValue("restart_pout", 32'(pout), 32'h10);
    idleCycle(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 15),
                    1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
    $finish;
  end

endmodule
